// File: rtl/seq_divider16.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done handshake.
// Optional two's-complement mode when SEQ_DIVIDER16_SIGNED_EN is defined (adds sign_mode).
module seq_divider16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER16_SIGNED_EN
  input  logic             sign_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] qw_q, qw_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  logic             sm;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             borrow;

`ifdef SEQ_DIVIDER16_SIGNED_EN
  assign sm = sign_mode;
`else
  assign sm = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Shift the next dividend bit into the partial remainder; the extra MSB
  // keeps remainders at or above 2^(WIDTH-1) comparing correctly.
  assign rem_sh          = {rem_q, qw_q[WIDTH-1]};
  assign {borrow, trial} = {1'b0, rem_sh} - {2'b00, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    qw_d    = qw_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d   = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            negq_d  = sm & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            negr_d  = sm & dividend[WIDTH-1];
            qw_d    = neg_if(dividend, sm & dividend[WIDTH-1]);
            dvs_d   = neg_if(divisor, sm & divisor[WIDTH-1]);
            rem_d   = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        qw_d  = {qw_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          quo_d   = neg_if(qw_d, negq_q);
          rmd_d   = neg_if(rem_d, negr_q);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      qw_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      qw_q    <= qw_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule
